// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
// State encodings are plain constants so legacy tools can consume them.
package mem_bus_arbiter_pkg;

  localparam int IO_BIT_DEF = 22;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_RAM_WAIT = 2'd1;
  localparam state_t ST_RESP     = 2'd2;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - core, RAM and IO signals shared by the arbiter and its environment
// slave is the arbiter's view; master is the view of the core/memory side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              fReq;
  logic [ADDR_W-1:0] fAddr;
  logic              fGnt;
  logic              fValid;
  logic [DATA_W-1:0] fRdata;
  logic              fFault;

  logic              dReq;
  logic              dWe;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWdata;
  logic [MASK_W-1:0] dWMask;
  logic              dGnt;
  logic              dValid;
  logic [DATA_W-1:0] dRdata;

  logic              ramEn;
  logic [MASK_W-1:0] ramWMask;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWdata;
  logic [DATA_W-1:0] ramRdata;

  logic              ioWe;
  logic              ioRe;
  logic [ADDR_W-1:0] ioAddr;
  logic [DATA_W-1:0] ioWdata;
  logic [DATA_W-1:0] ioRdata;

  logic              busy;

  modport slave (
    input  fReq, fAddr, dReq, dWe, dAddr, dWdata, dWMask, ramRdata, ioRdata,
    output fGnt, fValid, fRdata, fFault, dGnt, dValid, dRdata,
           ramEn, ramWMask, ramAddr, ramWdata, ioWe, ioRe, ioAddr, ioWdata, busy
  );

  modport master (
    output fReq, fAddr, dReq, dWe, dAddr, dWdata, dWMask, ramRdata, ioRdata,
    input  fGnt, fValid, fRdata, fFault, dGnt, dValid, dRdata,
           ramEn, ramWMask, ramAddr, ramWdata, ioWe, ioRe, ioAddr, ioWdata, busy
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one RAM port and the IO space between fetch and load/store
// One transaction outstanding; grants are combinational in IDLE, read data returns via RESP.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IO_BIT     = IO_BIT_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int STREAK_W = $clog2(STARVE_LIM + 1);

  state_t              r_state;
  owner_t              r_owner;
  logic [STREAK_W-1:0] r_streak;
  logic [1:0]          r_lat_cnt;
  logic [DATA_W-1:0]   r_cap;
  logic [DATA_W-1:0]   r_f_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_fault;

  logic w_idle;
  logic w_resp;
  logic w_f_io;
  logic w_d_io;
  logic w_starved;
  logic w_pick_f;
  logic w_pick_d;

  // Reset gates every combinational output so the bus is quiet while reset is held.
  assign w_idle    = (r_state == ST_IDLE) && !reset;
  assign w_resp    = (r_state == ST_RESP) && !reset;
  assign w_f_io    = bus.fAddr[IO_BIT];
  assign w_d_io    = bus.dAddr[IO_BIT];
  assign w_starved = (r_streak == STREAK_W'(STARVE_LIM));
  assign w_pick_f  = w_idle && bus.fReq && (!bus.dReq || w_starved);
  assign w_pick_d  = w_idle && bus.dReq && !w_pick_f;

  always_comb begin
    bus.fGnt     = w_pick_f;
    bus.dGnt     = w_pick_d;
    bus.ramEn    = 1'b0;
    bus.ramWMask = '0;
    bus.ramAddr  = '0;
    bus.ramWdata = '0;
    bus.ioWe     = 1'b0;
    bus.ioRe     = 1'b0;
    bus.ioAddr   = '0;
    bus.ioWdata  = '0;
    // A fetch into the IO region never touches the IO space; it only faults.
    if (w_pick_f && !w_f_io) begin
      bus.ramEn   = 1'b1;
      bus.ramAddr = bus.fAddr;
    end
    if (w_pick_d) begin
      if (w_d_io) begin
        bus.ioAddr = bus.dAddr;
        bus.ioWe   = bus.dWe;
        bus.ioRe   = !bus.dWe;
        if (bus.dWe) begin
          bus.ioWdata = bus.dWdata;
        end
      end else begin
        bus.ramEn   = 1'b1;
        bus.ramAddr = bus.dAddr;
        if (bus.dWe) begin
          bus.ramWMask = bus.dWMask;
          bus.ramWdata = bus.dWdata;
        end
      end
    end
  end

  assign bus.fValid = w_resp && (r_owner == OWN_FETCH);
  assign bus.dValid = w_resp && (r_owner == OWN_DATA);
  assign bus.fFault = bus.fValid && r_fault;
  assign bus.fRdata = bus.fValid ? r_cap : r_f_rdata;
  assign bus.dRdata = bus.dValid ? r_cap : r_d_rdata;
  assign bus.busy   = (r_state != ST_IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_FETCH;
      r_streak  <= '0;
      r_lat_cnt <= '0;
      r_cap     <= '0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
      r_fault   <= 1'b0;
    end else begin
      if (!bus.fReq || w_pick_f) begin
        r_streak <= '0;
      end else if (w_pick_d && !w_starved) begin
        r_streak <= r_streak + STREAK_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pick_f) begin
            r_owner <= OWN_FETCH;
            if (w_f_io) begin
              r_fault <= 1'b1;
              r_cap   <= '0;
              r_state <= ST_RESP;
            end else begin
              r_fault   <= 1'b0;
              r_lat_cnt <= 2'(MEM_LAT - 1);
              r_state   <= ST_RAM_WAIT;
            end
          end else if (w_pick_d && !bus.dWe) begin
            r_owner <= OWN_DATA;
            r_fault <= 1'b0;
            if (w_d_io) begin
              r_cap   <= bus.ioRdata;
              r_state <= ST_RESP;
            end else begin
              r_lat_cnt <= 2'(MEM_LAT - 1);
              r_state   <= ST_RAM_WAIT;
            end
          end
        end
        ST_RAM_WAIT: begin
          if (r_lat_cnt == 2'd0) begin
            r_cap   <= bus.ramRdata;
            r_state <= ST_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          if (r_owner == OWN_FETCH) begin
            r_f_rdata <= r_cap;
          end else begin
            r_d_rdata <= r_cap;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter (MEM_LAT 1 and 3 instances)
module tb_mem_bus_arbiter;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] ram_a   [0:63];
  logic [31:0] ram_b   [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] pipe_b  [0:1];

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .IO_BIT(22), .MEM_LAT(1), .STARVE_LIM(4))
    dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .IO_BIT(22), .MEM_LAT(3), .STARVE_LIM(4))
    dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  always #5 clk = ~clk;

  function automatic logic [31:0] io_val(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign bus_a.ioRdata = io_val(bus_a.ioAddr);
  assign bus_b.ioRdata = 32'h0;

  // RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (bus_a.ramEn) begin
      for (int k = 0; k < 4; k++)
        if (bus_a.ramWMask[k]) ram_a[bus_a.ramAddr[7:2]][8*k +: 8] <= bus_a.ramWdata[8*k +: 8];
      bus_a.ramRdata <= ram_a[bus_a.ramAddr[7:2]];
    end
  end

  // RAM with 3-cycle read latency
  always @(posedge clk) begin
    pipe_b[0]      <= bus_b.ramEn ? ram_b[bus_b.ramAddr[7:2]] : 32'hDEAD0000;
    pipe_b[1]      <= pipe_b[0];
    bus_b.ramRdata <= pipe_b[1];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.fReq = 0; bus_a.fAddr = 0; bus_a.dReq = 0; bus_a.dWe = 0;
    bus_a.dAddr = 0; bus_a.dWdata = 0; bus_a.dWMask = 0;
  endtask

  task automatic idle_b();
    bus_b.fReq = 0; bus_b.fAddr = 0; bus_b.dReq = 0; bus_b.dWe = 0;
    bus_b.dAddr = 0; bus_b.dWdata = 0; bus_b.dWMask = 0;
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    idle_a(); idle_b();
    rst_a = 1; rst_b = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {bus_a.fGnt, bus_a.fValid, bus_a.fFault, bus_a.dGnt, bus_a.dValid, bus_a.ramEn,
            bus_a.ramWMask, bus_a.ioWe, bus_a.ioRe, bus_a.busy};
    checks++;
    if (outs !== 13'h0) begin errors++; $display("FAIL reset_ctrl_a got=%h exp=0", outs); end
    checks++;
    if ({bus_a.fRdata, bus_a.dRdata, bus_a.ramAddr, bus_a.ioAddr} !== 128'h0) begin
      errors++; $display("FAIL reset_data_a got=%h/%h exp=0", bus_a.fRdata, bus_a.dRdata);
    end
    checks++;
    if ({bus_b.busy, bus_b.dValid, bus_b.dRdata} !== 34'h0) begin
      errors++; $display("FAIL reset_b got=%h exp=0", {bus_b.busy, bus_b.dValid, bus_b.dRdata});
    end
    step(); rst_a = 0; rst_b = 0;
    @(negedge clk);
    checks++;
    if ({bus_a.busy, bus_a.fGnt, bus_a.dGnt} !== 3'b000) begin
      errors++; $display("FAIL reset_release got=%b exp=000", {bus_a.busy, bus_a.fGnt, bus_a.dGnt});
    end
  endtask

  task automatic test_fetch_basic();
    step(); bus_a.fReq = 1; bus_a.fAddr = 32'h10;
    @(negedge clk);
    checks++;
    if ({bus_a.fGnt, bus_a.ramEn, bus_a.ramWMask, bus_a.ramAddr} !== {6'b110000, 32'h10}) begin
      errors++; $display("FAIL fetch_gnt got=%b/%h exp=110000/10", {bus_a.fGnt, bus_a.ramEn, bus_a.ramWMask}, bus_a.ramAddr);
    end
    step(); bus_a.fReq = 0;
    @(negedge clk);
    checks++;
    if ({bus_a.fValid, bus_a.busy} !== 2'b01) begin
      errors++; $display("FAIL fetch_wait got=%b exp=01", {bus_a.fValid, bus_a.busy});
    end
    step(); @(negedge clk);
    checks++;
    if ({bus_a.fValid, bus_a.fFault, bus_a.fRdata} !== {2'b10, 32'h00500093}) begin
      errors++; $display("FAIL fetch_valid got=%b/%h exp=10/00500093", {bus_a.fValid, bus_a.fFault}, bus_a.fRdata);
    end
    step(); @(negedge clk);
    checks++;
    if ({bus_a.fValid, bus_a.busy, bus_a.fRdata} !== {2'b00, 32'h00500093}) begin
      errors++; $display("FAIL fetch_hold got=%b/%h exp=00/00500093", {bus_a.fValid, bus_a.busy}, bus_a.fRdata);
    end
  endtask

  task automatic test_simul();
    logic [5:0] efg = 6'b001000;
    logic [5:0] edg = 6'b000001;
    logic [5:0] efv = 6'b100000;
    logic [5:0] edv = 6'b000100;
    for (int c = 0; c < 6; c++) begin
      step();
      bus_a.fReq = (c <= 3); bus_a.fAddr = 32'h10;
      bus_a.dReq = (c == 0); bus_a.dWe = 0; bus_a.dAddr = 32'h20;
      @(negedge clk);
      checks++;
      if ({bus_a.fGnt, bus_a.dGnt, bus_a.fValid, bus_a.dValid} !== {efg[c], edg[c], efv[c], edv[c]}) begin
        errors++;
        $display("FAIL simul_c%0d got=%b exp=%b", c, {bus_a.fGnt, bus_a.dGnt, bus_a.fValid, bus_a.dValid},
                 {efg[c], edg[c], efv[c], edv[c]});
      end
      if (c == 2) begin
        checks++;
        if (bus_a.dRdata !== 32'h12345678) begin
          errors++; $display("FAIL simul_drdata got=%h exp=12345678", bus_a.dRdata);
        end
      end
    end
    idle_a();
  endtask

  task automatic test_starve();
    logic [7:0] efg = 8'b00010000;
    logic [7:0] edg = 8'b10001111;
    logic [7:0] efv = 8'b01000000;
    for (int c = 0; c < 8; c++) begin
      step();
      bus_a.fReq = (c <= 4); bus_a.fAddr = 32'h10;
      bus_a.dReq = 1; bus_a.dWe = 1; bus_a.dAddr = 32'h40;
      bus_a.dWdata = 32'hA0000000 | 32'(c); bus_a.dWMask = 4'hF;
      @(negedge clk);
      checks++;
      if ({bus_a.fGnt, bus_a.dGnt, bus_a.fValid, bus_a.dValid, bus_a.ramWMask} !==
          {efg[c], edg[c], efv[c], 1'b0, edg[c] ? 4'hF : 4'h0}) begin
        errors++;
        $display("FAIL starve_c%0d got=%b exp=%b", c,
                 {bus_a.fGnt, bus_a.dGnt, bus_a.fValid, bus_a.dValid, bus_a.ramWMask},
                 {efg[c], edg[c], efv[c], 1'b0, edg[c] ? 4'hF : 4'h0});
      end
    end
    idle_a();
    step();
  endtask

  task automatic test_dmask_zero();
    step(); bus_a.dReq = 1; bus_a.dWe = 1; bus_a.dAddr = 32'h10; bus_a.dWdata = 32'hFFFFFFFF; bus_a.dWMask = 4'h0;
    @(negedge clk);
    checks++;
    if ({bus_a.dGnt, bus_a.ramEn, bus_a.ramWMask} !== 6'b110000) begin
      errors++; $display("FAIL mask0_store got=%b exp=110000", {bus_a.dGnt, bus_a.ramEn, bus_a.ramWMask});
    end
    step(); idle_a(); bus_a.fReq = 1; bus_a.fAddr = 32'h10;
    @(negedge clk);
    checks++;
    if (bus_a.fGnt !== 1'b1) begin errors++; $display("FAIL mask0_fgnt got=%b exp=1", bus_a.fGnt); end
    step(); bus_a.fReq = 0;
    step(); @(negedge clk);
    checks++;
    if ({bus_a.fValid, bus_a.fRdata} !== {1'b1, 32'h00500093}) begin
      errors++; $display("FAIL mask0_readback got=%b/%h exp=1/00500093", bus_a.fValid, bus_a.fRdata);
    end
  endtask

  task automatic test_io();
    step(); bus_a.dReq = 1; bus_a.dWe = 1; bus_a.dAddr = 32'h400004; bus_a.dWdata = 32'h1F; bus_a.dWMask = 4'hF;
    @(negedge clk);
    checks++;
    if ({bus_a.dGnt, bus_a.ioWe, bus_a.ioRe, bus_a.ramEn, bus_a.ioWdata, bus_a.ioAddr} !==
        {4'b1100, 32'h1F, 32'h400004}) begin
      errors++;
      $display("FAIL io_store got=%b/%h/%h exp=1100/1f/400004", {bus_a.dGnt, bus_a.ioWe, bus_a.ioRe, bus_a.ramEn},
               bus_a.ioWdata, bus_a.ioAddr);
    end
    step(); bus_a.dWe = 0; bus_a.dAddr = 32'h400008;
    @(negedge clk);
    checks++;
    if ({bus_a.dValid, bus_a.dGnt, bus_a.ioRe, bus_a.ioWe} !== 4'b0110) begin
      errors++; $display("FAIL io_load_gnt got=%b exp=0110", {bus_a.dValid, bus_a.dGnt, bus_a.ioRe, bus_a.ioWe});
    end
    step(); idle_a();
    @(negedge clk);
    checks++;
    if ({bus_a.dValid, bus_a.dRdata} !== {1'b1, 32'hC0DE0008}) begin
      errors++; $display("FAIL io_load_data got=%b/%h exp=1/c0de0008", bus_a.dValid, bus_a.dRdata);
    end
  endtask

  task automatic test_io_fetch_fault();
    step(); bus_a.fReq = 1; bus_a.fAddr = 32'h400000;
    @(negedge clk);
    checks++;
    if ({bus_a.fGnt, bus_a.ioRe, bus_a.ramEn} !== 3'b100) begin
      errors++; $display("FAIL ifetch_gnt got=%b exp=100", {bus_a.fGnt, bus_a.ioRe, bus_a.ramEn});
    end
    step(); bus_a.fReq = 0;
    @(negedge clk);
    checks++;
    if ({bus_a.fValid, bus_a.fFault, bus_a.ioRe, bus_a.fRdata} !== {3'b110, 32'h0}) begin
      errors++; $display("FAIL ifetch_fault got=%b/%h exp=110/0", {bus_a.fValid, bus_a.fFault, bus_a.ioRe}, bus_a.fRdata);
    end
  endtask

  task automatic test_lat3_reset_mid();
    logic [5:0] edv = 6'b010000;
    logic [5:0] edg = 6'b000001;
    logic [5:0] ebz = 6'b011110;
    for (int c = 0; c < 6; c++) begin
      step();
      bus_b.dReq = (c == 0); bus_b.dWe = 0; bus_b.dAddr = 32'h10;
      @(negedge clk);
      checks++;
      if ({bus_b.dGnt, bus_b.dValid, bus_b.busy} !== {edg[c], edv[c], ebz[c]}) begin
        errors++; $display("FAIL lat3_c%0d got=%b exp=%b", c, {bus_b.dGnt, bus_b.dValid, bus_b.busy}, {edg[c], edv[c], ebz[c]});
      end
      if (c == 4) begin
        checks++;
        if (bus_b.dRdata !== 32'hCAFE0004) begin errors++; $display("FAIL lat3_data got=%h exp=cafe0004", bus_b.dRdata); end
      end
    end
    step(); bus_b.dReq = 1;
    step(); bus_b.dReq = 0;
    step(); rst_b = 1;
    @(negedge clk);
    checks++;
    if ({bus_b.dGnt, bus_b.dValid, bus_b.busy, bus_b.ramEn, bus_b.ioRe, bus_b.ioWe} !== 6'b0) begin
      errors++; $display("FAIL rstmid_outs got=%b exp=0", {bus_b.dGnt, bus_b.dValid, bus_b.busy, bus_b.ramEn, bus_b.ioRe, bus_b.ioWe});
    end
    step(); rst_b = 0;
    @(negedge clk);
    checks++;
    if ({bus_b.busy, bus_b.dValid, bus_b.dRdata} !== 34'h0) begin
      errors++; $display("FAIL rstmid_after got=%b/%h exp=0/0", {bus_b.busy, bus_b.dValid}, bus_b.dRdata);
    end
    for (int c = 0; c < 5; c++) begin
      step(); @(negedge clk);
      checks++;
      if (bus_b.dValid !== 1'b0) begin errors++; $display("FAIL rstmid_dvalid_c%0d got=1 exp=0", c); end
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 4) == 0) a = a | 32'h00400000;
    return a;
  endfunction

  task automatic test_random();
    logic f_pend = 0, d_pend = 0, d_we = 0, fr;
    logic [31:0] f_addr = 0, d_addr = 0, d_wdata = 0, r_data = 0;
    logic [3:0] d_mask = 0;
    logic r_own = 0, r_fault = 0, exp_f, exp_d, exp_busy, exp_fv, exp_dv;
    int resp_cyc = -1;
    int streak = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = ram_a[i];
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      if (!f_pend && $urandom_range(0, 2) != 0) begin f_pend = 1; f_addr = rnd_addr(); end
      if (!d_pend && $urandom_range(0, 3) != 0) begin
        d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr();
        d_wdata = $urandom; d_mask = 4'($urandom_range(0, 15));
      end
      bus_a.fReq = f_pend; bus_a.fAddr = f_addr;
      bus_a.dReq = d_pend; bus_a.dWe = d_we; bus_a.dAddr = d_addr; bus_a.dWdata = d_wdata; bus_a.dWMask = d_mask;
      @(negedge clk);
      exp_busy = (resp_cyc >= 0) && (cyc <= resp_cyc);
      exp_f    = !exp_busy && f_pend && (!d_pend || streak == 4);
      exp_d    = !exp_busy && d_pend && !exp_f;
      exp_fv   = (cyc == resp_cyc) && !r_own;
      exp_dv   = (cyc == resp_cyc) && r_own;
      checks++;
      if ({bus_a.fGnt, bus_a.dGnt, bus_a.busy, bus_a.fValid, bus_a.dValid} !== {exp_f, exp_d, exp_busy, exp_fv, exp_dv}) begin
        errors++;
        $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, {bus_a.fGnt, bus_a.dGnt, bus_a.busy, bus_a.fValid, bus_a.dValid},
                 {exp_f, exp_d, exp_busy, exp_fv, exp_dv});
      end
      if (exp_fv) begin
        checks++;
        if ({bus_a.fFault, bus_a.fRdata} !== {r_fault, r_data}) begin
          errors++; $display("FAIL rnd_fetch cyc=%0d got=%b/%h exp=%b/%h", cyc, bus_a.fFault, bus_a.fRdata, r_fault, r_data);
        end
      end
      if (exp_dv) begin
        checks++;
        if (bus_a.dRdata !== r_data) begin
          errors++; $display("FAIL rnd_load cyc=%0d got=%h exp=%h", cyc, bus_a.dRdata, r_data);
        end
      end
      fr = f_pend;
      if (exp_d) begin
        if (d_we && d_addr[22]) begin
          checks++;
          if ({bus_a.ioWe, bus_a.ioWdata} !== {1'b1, d_wdata}) begin
            errors++; $display("FAIL rnd_iowr cyc=%0d got=%b/%h exp=1/%h", cyc, bus_a.ioWe, bus_a.ioWdata, d_wdata);
          end
        end else if (d_we) begin
          checks++;
          if ({bus_a.ramEn, bus_a.ramWMask} !== {1'b1, d_mask}) begin
            errors++; $display("FAIL rnd_ramwr cyc=%0d got=%b exp=1%b", cyc, {bus_a.ramEn, bus_a.ramWMask}, d_mask);
          end
          for (int k = 0; k < 4; k++)
            if (d_mask[k]) ref_mem[d_addr[7:2]][8*k +: 8] = d_wdata[8*k +: 8];
        end else begin
          resp_cyc = cyc + (d_addr[22] ? 1 : 2);
          r_own = 1; r_fault = 0;
          r_data = d_addr[22] ? io_val(d_addr) : ref_mem[d_addr[7:2]];
        end
        d_pend = 0;
      end
      if (exp_f) begin
        resp_cyc = cyc + (f_addr[22] ? 1 : 2);
        r_own = 0; r_fault = f_addr[22];
        r_data = f_addr[22] ? 32'h0 : ref_mem[f_addr[7:2]];
        f_pend = 0;
      end
      if (!fr || exp_f) streak = 0;
      else if (exp_d && streak < 4) streak++;
    end
    idle_a();
    repeat (4) step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_a[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
      ram_b[i] = 32'h10000000 + 32'(i);
    end
    ram_a[4] = 32'h00500093;
    ram_a[8] = 32'h12345678;
    ram_b[4] = 32'hCAFE0004;
    idle_a(); idle_b();
    test_reset();
    test_fetch_basic();
    test_simul();
    test_starve();
    test_dmask_zero();
    test_io();
    test_io_fetch_fault();
    test_lat3_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
